vga_capture: RTL and testbench

Receive-side VGA timing recovery and pixel capture block. It samples an incoming hsync/vsync/RGB stream on the pixel clock and checks its timing against the 640x480@60 parameter set. It locks onto the frame structure and emits a coordinate-tagged RGB555 pixel stream for the frame buffer or a loopback checker. It sits at the far end of the VGA link from the display driver and is used for on-chip loopback self-test.

---
 rtl/vga_capture.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: receive-side VGA timing recovery and RGB555 capture.
// Locks onto the sync structure and tags active pixels with x/y.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   hsync_in/vsync_in active-low syncs from the link
//   red/green/blue_in 8-bit colour per channel
//   pix_valid/x/y/rgb captured active pixel, RGB555
//   frame_start       first pixel (0,0) of a locked frame
//   locked            timing lock held
//   line_err          bad line length while locked (pulse)
//   frame_err         bad line count or missing vsync while locked (pulse)

module vga_capture #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [14:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [9:0] C_MAX   = 10'd1023;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_OFS   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] X_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] Y_OFS   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] Y_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] V_LINES = 10'(V_TOTAL);
  localparam logic [3:0] GOOD_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic        hs1, hs2;
  logic        vs1, vs2;
  logic [14:0] rgb1, rgb2;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  lines;
  logic        seen_hs;
  logic        v_arm;
  logic        frame_ok;
  logic [3:0]  good_cnt, good_n;
  logic [3:0]  good_inc;

  logic        hs_fall, vs_fall;
  logic        new_frame;
  logic        line_bad;
  logic        frame_bad;
  logic        v_timeout;
  logic        lerr_n, ferr_n;
  logic        in_win;
  logic        pix_ok;

  // Only the RGB555 bits are kept; the low colour bits are dropped.
  logic unused_lsb;
  assign unused_lsb = ^{red_in[2:0], green_in[2:0], blue_in[2:0]};

  // Input register plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs1  <= 1'b1;
      hs2  <= 1'b1;
      vs1  <= 1'b1;
      vs2  <= 1'b1;
      rgb1 <= '0;
      rgb2 <= '0;
    end else begin
      hs1  <= hsync_in;
      hs2  <= hs1;
      vs1  <= vsync_in;
      vs2  <= vs1;
      rgb1 <= {red_in[7:3], green_in[7:3], blue_in[7:3]};
      rgb2 <= rgb1;
    end
  end

  assign hs_fall   = !hs1 && hs2;
  assign vs_fall   = !vs1 && vs2;
  assign new_frame = vs_fall || v_arm;

  // The hsync fall that coincides with a vsync fall closes the
  // last line of the previous frame, so it is judged with it.
  assign line_bad  = hs_fall && !(seen_hs && (h_cnt == H_LAST));
  assign frame_bad = (lines != V_LINES) || !frame_ok || line_bad;
  assign v_timeout = hs_fall && !new_frame && (v_cnt == C_MAX - 10'd1);
  assign good_inc  = good_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt    <= C_MAX;
      v_cnt    <= C_MAX;
      lines    <= '0;
      seen_hs  <= 1'b0;
      v_arm    <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_cnt   <= '0;
        seen_hs <= 1'b1;
      end else if (h_cnt != C_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end

      if (hs_fall) begin
        if (new_frame) begin
          v_cnt <= '0;
        end else if (v_cnt != C_MAX) begin
          v_cnt <= v_cnt + 10'd1;
        end
      end

      if (hs_fall) begin
        v_arm <= 1'b0;
      end else if (vs_fall) begin
        v_arm <= 1'b1;
      end

      // Line count since the last vsync fall, including a
      // coincident hsync fall, which opens the new frame.
      if (vs_fall) begin
        lines    <= {9'd0, hs_fall};
        frame_ok <= 1'b1;
      end else begin
        if (hs_fall && (lines != C_MAX)) begin
          lines <= lines + 10'd1;
        end
        if (line_bad) begin
          frame_ok <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    lerr_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          if (frame_bad) begin
            good_n = '0;
          end else begin
            good_n = good_inc;
            if (good_inc == GOOD_N) begin
              state_n = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        lerr_n = line_bad;
        ferr_n = (vs_fall && frame_bad) || v_timeout;
        if (lerr_n || ferr_n) begin
          state_n = SEARCH;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
  end

  assign in_win = (h_cnt >= X_OFS) && (h_cnt <= X_END) &&
                  (v_cnt >= Y_OFS) && (v_cnt <= Y_END);

  // A losing cycle never emits a pixel, even if the window is open.
  assign pix_ok = (state == LOCKED) && in_win && !lerr_n && !ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid   <= pix_ok;
      pix_x       <= h_cnt - X_OFS;
      pix_y       <= v_cnt - Y_OFS;
      pix_rgb     <= rgb2;
      frame_start <= pix_ok && (h_cnt == X_OFS) && (v_cnt == Y_OFS);
      line_err    <= lerr_n;
      frame_err   <= ferr_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench for vga_capture.
// Uses a scaled-down timing set so many frames fit in a short run.

module tb_vga_capture;

  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 8;
  localparam int HT = 20;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 4;
  localparam int VT = 12;
  localparam int XO = HS + HB;
  localparam int YO = VS + VB;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [7:0]  red_in = '0;
  logic [7:0]  green_in = '0;
  logic [7:0]  blue_in = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [14:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        line_err;
  logic        frame_err;

  vga_capture #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .red_in(red_in),
    .green_in(green_in),
    .blue_in(blue_in),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_rgb(pix_rgb),
    .frame_start(frame_start),
    .locked(locked),
    .line_err(line_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int n_valid = 0;
  int n_lerr = 0;
  int n_ferr = 0;
  int pix_err = 0;
  int lock_rise = -1;
  int lock_fall = -1;
  int lerr_cyc = -1;
  int ferr_cyc = -1;
  int fs_cyc = -1;
  logic [14:0] rgb_last = '0;

  initial begin
    int ex_x = 0;
    int ex_y = 0;
    logic lk_q = 1'b0;
    forever begin
      @(negedge clk);
      if (locked && !lk_q) lock_rise = cyc;
      if (!locked && lk_q) lock_fall = cyc;
      lk_q = locked;
      if (line_err) begin
        n_lerr++;
        lerr_cyc = cyc;
      end
      if (frame_err) begin
        n_ferr++;
        ferr_cyc = cyc;
      end
      if (frame_start) fs_cyc = cyc;
      if (frame_start && !pix_valid) pix_err++;
      if (!locked) begin
        ex_x = 0;
        ex_y = 0;
      end
      if (pix_valid) begin
        n_valid++;
        if (pix_x != 10'(ex_x) || pix_y != 10'(ex_y)) pix_err++;
        if (pix_rgb != {5'(ex_x), 5'(ex_y), 5'd20}) pix_err++;
        if (frame_start != (ex_x == 0 && ex_y == 0)) pix_err++;
        if (pix_x == 10'd7 && pix_y == 10'd3) rgb_last = pix_rgb;
        ex_x++;
        if (ex_x == HA) begin
          ex_x = 0;
          ex_y++;
          if (ex_y == VA) ex_y = 0;
        end
      end
    end
  end

  int line_cyc[1100];
  int vs_cyc = 0;
  int rst_cyc = 0;
  logic [4:0]  snap_a = '1;
  logic [34:0] snap_b = '1;
  logic        pre_valid = 1'b0;

  // One frame of nlines lines; line short_ln is one cycle short,
  // and reset pulses for one cycle at (rst_ln, rst_col).
  task automatic run_frame(input int nlines, input bit with_vs,
                           input int short_ln, input int rst_ln,
                           input int rst_col);
    bit snap = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      int len = (l == short_ln) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (snap) begin
          snap_a = {pix_valid, locked, line_err, frame_err, frame_start};
          snap_b = {pix_rgb, pix_x, pix_y};
          snap = 1'b0;
        end
        if (c == 0) line_cyc[l] = cyc;
        if (l == 0 && c == 0) vs_cyc = cyc;
        reset = (l == rst_ln && c == rst_col);
        if (reset) begin
          rst_cyc = cyc;
          pre_valid = pix_valid;
          snap = 1'b1;
        end
        hsync_in = (c >= HS);
        vsync_in = !(with_vs && l < VS);
        red_in   = 8'((c - XO) * 8 + 3);
        green_in = 8'((l - YO) * 8 + 5);
        blue_in  = 8'hA5;
      end
    end
  endtask

  initial begin
    int n0;
    int e0;
    int f0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {pix_valid, locked, line_err, frame_err, frame_start}, 0);
    chk("rst_data", {pix_rgb, pix_x, pix_y}, 0);

    run_frame(VT, 1, -1, -1, -1);
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    chk("f2_pix", n_valid - n0, 0);
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    chk("lock_rise", lock_rise, vs_cyc + 2);
    chk("f3_pix", n_valid - n0, NPIX);
    chk("fs_lat", fs_cyc, line_cyc[YO] + 3 + XO);
    chk("rgb_7_3", rgb_last, {5'd7, 5'd3, 5'd20});
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    chk("f4_pix", n_valid - n0, NPIX);
    chk("f4_locked", locked, 1);

    e0 = n_lerr;
    f0 = n_ferr;
    n0 = n_valid;
    run_frame(VT, 1, YO + 1, -1, -1);
    chk("lerr_cnt", n_lerr - e0, 1);
    chk("lerr_at", lerr_cyc, line_cyc[YO + 2] + 2);
    chk("lerr_drop", lock_fall, lerr_cyc);
    chk("lerr_noferr", n_ferr - f0, 0);
    chk("f5_pix", n_valid - n0, 2 * HA);
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    run_frame(VT, 1, -1, -1, -1);
    chk("relock_pix", n_valid - n0, 0);
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    chk("relock_rise", lock_rise, vs_cyc + 2);
    chk("f8_pix", n_valid - n0, NPIX);

    e0 = n_lerr;
    f0 = n_ferr;
    n0 = n_valid;
    run_frame(1040, 0, -1, -1, -1);
    chk("ferr_cnt", n_ferr - f0, 1);
    chk("ferr_at", ferr_cyc, line_cyc[1023 - VT] + 2);
    chk("ferr_drop", lock_fall, ferr_cyc);
    chk("ferr_nolerr", n_lerr - e0, 0);
    chk("search_hold", locked, 0);
    chk("novs_pix", n_valid - n0, 0);

    e0 = n_lerr;
    f0 = n_ferr;
    run_frame(VT, 1, -1, -1, -1);
    run_frame(VT - 1, 1, -1, -1, -1);
    run_frame(VT, 1, -1, -1, -1);
    run_frame(VT, 1, -1, -1, -1);
    chk("no_early_lock", locked, 0);
    run_frame(VT, 1, -1, -1, -1);
    chk("short_frame_rise", lock_rise, vs_cyc + 2);
    chk("measure_no_err", (n_lerr - e0) + (n_ferr - f0), 0);

    run_frame(VT, 1, -1, YO + 2, XO + 4);
    chk("pre_rst_valid", pre_valid, 1);
    chk("mid_rst_ctl", snap_a, 0);
    chk("mid_rst_data", snap_b, 0);
    run_frame(VT, 1, -1, -1, -1);
    run_frame(VT, 1, -1, -1, -1);
    chk("rst_no_lock", locked, 0);
    n0 = n_valid;
    run_frame(VT, 1, -1, -1, -1);
    chk("rst_relock", lock_rise, vs_cyc + 2);
    chk("f18_pix", n_valid - n0, NPIX);
    chk("f18_fs_lat", fs_cyc, line_cyc[YO] + 3 + XO);

    chk("pix_stream", pix_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
